// File: rtl/uart_receiver.sv
// Memory-mapped 8N1 UART receiver: 2-flop input sync, receive FSM, byte FIFO, status/data registers.
// Latency: uart_rx reaches the FSM 2 cycles later; a byte is pushed on the stop-bit sample cycle; reads return next cycle.
// Backpressure: none on the serial line; when the FIFO is full a completed byte is dropped and the sticky overrun flag is set.
module uart_receiver #(
  parameter logic [31:0] BASE_ADDRESS = 32'h18,
  parameter int          BAUD_DIVIDE  = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  input  logic        uart_rx,
  output logic        rx_overrun
);

  localparam int BW = $clog2(BAUD_DIVIDE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] HALF_LOAD = BW'(BAUD_DIVIDE / 2 - 1);
  localparam logic [BW-1:0] FULL_LOAD = BW'(BAUD_DIVIDE - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t          state;
  logic            rx_meta;
  logic            rx_s;
  logic [BW-1:0]   baud_count;
  logic [2:0]      bit_count;
  logic [7:0]      shift_reg;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            overrun;
  logic            framing_error;
  logic [3:0]      occ_sat;

  logic baud_zero, stop_sample, push_req, frame_bad;
  logic sel_status, sel_data, fifo_empty, fifo_full;
  logic pop, push, overrun_set, wr_status;
  logic unused_ok;

  assign baud_zero   = (baud_count == '0);
  assign stop_sample = (state == STOP) && baud_zero;
  assign push_req    = stop_sample && rx_s;
  assign frame_bad   = stop_sample && !rx_s;

  assign sel_status  = (io_address == BASE_ADDRESS);
  assign sel_data    = (io_address == BASE_ADDRESS + 32'd4);
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == DEPTH_C);
  assign wr_status   = io_write_en && sel_status;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign pop         = io_read_en && sel_data && !fifo_empty;
  assign push        = push_req && (!fifo_full || pop);
  assign overrun_set = push_req && fifo_full && !pop;

  assign rx_overrun  = overrun;
  assign unused_ok   = ^{io_write_data[31:3], io_write_data[0]};

  // Occupancy field is 4 bits wide, so larger counts saturate.
  always_comb begin
    occ_sat = 4'hF;
    if (32'(count) < 32'd16) occ_sat = 4'(count);
  end

  // Two-flop synchronizer for the asynchronous serial pin; idles high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM: mid-bit sampling of start, 8 data bits LSB first, then stop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud_count <= '0;
      bit_count  <= '0;
      shift_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            baud_count <= HALF_LOAD;
            state      <= START;
          end
        end
        START: begin
          if (baud_zero) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              baud_count <= FULL_LOAD;
              bit_count  <= '0;
              state      <= DATA;
            end
          end else begin
            baud_count <= baud_count - 1'b1;
          end
        end
        DATA: begin
          if (baud_zero) begin
            shift_reg  <= {rx_s, shift_reg[7:1]};
            baud_count <= FULL_LOAD;
            if (bit_count == 3'd7) state <= STOP;
            else                   bit_count <= bit_count + 1'b1;
          end else begin
            baud_count <= baud_count - 1'b1;
          end
        end
        STOP: begin
          if (baud_zero) state <= rx_s ? IDLE : WAIT_IDLE;
          else           baud_count <= baud_count - 1'b1;
        end
        WAIT_IDLE: begin
          // A held-low line (break) must not be decoded as back-to-back frames.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_reg;
  end

  // FIFO pointers and occupancy count; count separates full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags, write-1-to-clear; a same-cycle set takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun       <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      overrun       <= overrun_set || (overrun && !(wr_status && io_write_data[1]));
      framing_error <= frame_bad || (framing_error && !(wr_status && io_write_data[2]));
    end
  end

  // Registered read port: updated on every read strobe, held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_read_data <= '0;
    end else if (io_read_en) begin
      if (sel_status)
        io_read_data <= {24'd0, occ_sat, 1'b0, framing_error, overrun, !fifo_empty};
      else if (sel_data && !fifo_empty)
        io_read_data <= {24'd0, mem[rd_ptr]};
      else
        io_read_data <= '0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed scenarios plus random frames, checked against a queue-based model.
// Read responses and the overrun pin are compared by one monitor process.
// Line activity is driven cycle by cycle so a data read can be placed on the stop-sample cycle.
module tb_uart_receiver;
  localparam int B = 20;
  localparam int H = B / 2;
  localparam int D = 8;
  localparam logic [31:0] ST = 32'h18;
  localparam logic [31:0] DA = 32'h1C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_write_en = 1'b0;
  logic        io_read_en = 1'b0;
  logic [31:0] io_address = '0;
  logic [31:0] io_write_data = '0;
  logic [31:0] io_read_data;
  logic        uart_rx = 1'b1;
  logic        rx_overrun;

  always #5 clk = ~clk;

  uart_receiver #(.BASE_ADDRESS(32'h18), .BAUD_DIVIDE(B), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .io_write_en(io_write_en), .io_read_en(io_read_en),
    .io_address(io_address), .io_write_data(io_write_data), .io_read_data(io_read_data),
    .uart_rx(uart_rx), .rx_overrun(rx_overrun)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: received bytes, sticky flags, expected read responses.
  logic [7:0]  m_q[$];
  bit          m_ov = 1'b0;
  bit          m_fe = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = '0;
  logic        rd_seen = 1'b0;
  bit          busy = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    int n;
    n = m_q.size();
    if (n > 15) n = 15;
    return {24'd0, 4'(n), 1'b0, m_fe, m_ov, (m_q.size() != 0)};
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == ST) return m_status();
    if (a == DA) begin
      if (m_q.size() == 0) return 32'd0;
      return {24'd0, m_q.pop_front()};
    end
    return 32'd0;
  endfunction

  function automatic void m_push(input logic [7:0] b);
    if (m_q.size() < D) m_q.push_back(b);
    else                m_ov = 1'b1;
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d);
    if (a == ST) begin
      if (d[1]) m_ov = 1'b0;
      if (d[2]) m_fe = 1'b0;
    end
  endfunction

  // Monitor: every read response, and the overrun pin whenever the model is settled.
  initial forever begin
    @(posedge clk);
    rd_seen = io_read_en;
    @(negedge clk);
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", io_read_data, 32'hDEAD_BEEF);
      end else begin
        check("read_data", io_read_data, exp_q.pop_front());
      end
      last_rd = io_read_data;
    end
    if (!busy) check("rx_overrun", {31'd0, rx_overrun}, {31'd0, m_ov});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    tick();
    exp_q.push_back(m_read(a));
    io_address = a;
    io_read_en = 1'b1;
    tick();
    io_read_en = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    busy = 1'b1;
    tick();
    m_write(a, d);
    io_address = a;
    io_write_data = d;
    io_write_en = 1'b1;
    tick();
    io_write_en = 1'b0;
    busy = 1'b0;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) tick();
  endtask

  // One 10-bit frame, B cycles per bit. pop_c places a data read so it is
  // registered on the stop-sample edge; abort_c pulses reset mid-frame.
  task automatic send_frame(input logic [7:0] b, input bit stop, input int pop_c, input int abort_c);
    int bi;
    busy = 1'b1;
    for (int c = 0; c < 10 * B; c++) begin
      tick();
      if (c == abort_c) begin
        uart_rx = 1'b1;
        io_read_en = 1'b0;
        reset = 1'b1;
        m_q.delete();
        m_ov = 1'b0;
        m_fe = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        busy = 1'b0;
        return;
      end
      bi = c / B;
      uart_rx = (bi == 0) ? 1'b0 : (bi == 9) ? stop : b[bi-1];
      io_read_en = 1'b0;
      if (c == pop_c) begin
        exp_q.push_back(m_read(DA));
        io_address = DA;
        io_read_en = 1'b1;
      end
    end
    tick();
    io_read_en = 1'b0;
    if (stop) m_push(b);
    else      m_fe = 1'b1;
    busy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    logic [7:0] rb;
    bit         rs;
    repeat (3) tick();
    reset = 1'b0;
    busy = 1'b0;

    // Reset state
    rd(ST); check("lit_reset_status", last_rd, 32'h0);
    rd(DA); check("lit_reset_data", last_rd, 32'h0);

    // Single frame
    send_frame(8'hA5, 1'b1, -1, -1);
    rd(ST); check("lit_a5_status", last_rd, 32'h11);
    rd(DA); check("lit_a5_data", last_rd, 32'hA5);
    rd(ST); check("lit_a5_empty", last_rd, 32'h0);

    // Overflow: nine frames into an eight-entry FIFO
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, -1, -1);
    idle(2);
    rd(ST); check("lit_full_status", last_rd, 32'h83);
    check("lit_overrun_pin", {31'd0, rx_overrun}, 32'd1);
    for (int i = 0; i < 8; i++) rd(DA);
    check("lit_last_byte", last_rd, 32'h07);
    rd(DA); check("lit_lost_byte", last_rd, 32'h0);
    wr(ST, 32'h2);
    rd(ST); check("lit_overrun_clr", last_rd, 32'h0);

    // Framing error with break, then recovery
    send_frame(8'h3C, 1'b0, -1, -1);
    busy = 1'b1;
    repeat (3 * B) tick();
    busy = 1'b0;
    rd(ST); check("lit_framing", last_rd, 32'h04);
    idle(B);
    send_frame(8'h55, 1'b1, -1, -1);
    rd(ST); check("lit_fe_plus_55", last_rd, 32'h15);
    wr(ST, 32'h4);
    rd(ST); check("lit_fe_clr", last_rd, 32'h11);
    rd(DA); check("lit_55", last_rd, 32'h55);

    // Short glitch on an idle line
    tick();
    uart_rx = 1'b0;
    repeat (5) tick();
    idle(3 * B);
    rd(ST); check("lit_glitch", last_rd, 32'h0);

    // Full FIFO with a pop on the exact stop-sample cycle
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, -1, -1);
    send_frame(8'h99, 1'b1, H + 2 + 9 * B, -1);
    check("lit_pop_oldest", last_rd, 32'h10);
    rd(ST); check("lit_pop_push_full", last_rd, 32'h81);
    for (int i = 0; i < 8; i++) rd(DA);
    check("lit_pop_newest", last_rd, 32'h99);

    // Reset during bit 4 with a byte already queued
    send_frame(8'h42, 1'b1, -1, -1);
    send_frame(8'h6B, 1'b1, -1, 5 * B + H);
    idle(B);
    rd(ST); check("lit_after_reset", last_rd, 32'h0);
    send_frame(8'h81, 1'b1, -1, -1);
    rd(ST); check("lit_81_status", last_rd, 32'h11);
    rd(DA); check("lit_81", last_rd, 32'h81);

    // Random frames, reads, clears and unmapped accesses
    for (int i = 0; i < 30; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      send_frame(rb, rs, -1, -1);
      if (!rs) idle($urandom_range(4, B));
      else     repeat ($urandom_range(0, 3)) tick();
      repeat ($urandom_range(0, 3)) rd(($urandom_range(0, 1) != 0) ? ST : DA);
      if ($urandom_range(0, 4) == 0) wr(ST, 32'($urandom_range(0, 7)));
      if ($urandom_range(0, 5) == 0) rd(32'h20);
    end
    idle(4);
    rd(ST);
    while (m_q.size() != 0) rd(DA);
    rd(ST);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Memory-mapped UART receive peripheral on the core's io bus; the core is the initiator and this block is the responder.
- Deserializes 8N1 frames from the board uart_rx pin into a byte FIFO. Software polls a status register and pops bytes by reading a data register.
- It is the receive counterpart to the UART transmit path used by the debug trace unit. It shares the same baud convention: clocks per bit = BAUD_DIVIDE.

Parameters:
- BASE_ADDRESS, 'h18: io address of the status register. The data register is at BASE_ADDRESS+4.
- BAUD_DIVIDE, 434: clk cycles per bit (50000000/115200). Must be >= 4.
- FIFO_DEPTH, 8: receive FIFO entries. Power of two, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- io_write_en  in  1  io bus write strobe, single cycle
- io_read_en  in  1  io bus read strobe, single cycle
- io_address  in  32  io bus byte address
- io_write_data  in  32  io bus write data
- io_read_data  out  32  read data, valid the cycle after io_read_en
- uart_rx  in  1  asynchronous serial input; idle high
- rx_overrun  out  1  sticky overrun flag (mirror of status bit1)

Behaviour:
- Reset values: io_read_data=0, rx_overrun=0, FIFO empty, framing_error=0, state IDLE, synchronizer flops=1, counters=0.
- Input sync: uart_rx passes through 2 flops (rx_s). All logic uses rx_s. Input-to-logic latency is 2 cycles.
- Receive FSM; bit_count 3 bits, baud_count wide enough for BAUD_DIVIDE-1:
  - IDLE: when rx_s==0, load baud_count=BAUD_DIVIDE/2-1 and go to START.
  - START: when baud_count reaches 0, sample rx_s. If it is 1, treat it as a glitch and return to IDLE. If it is 0, load BAUD_DIVIDE-1, set bit_count=0, go to DATA.
  - DATA: at each baud_count==0, shift rx_s in LSB first and reload BAUD_DIVIDE-1. After bit 7 is sampled, go to STOP.
  - STOP: at baud_count==0, sample the stop bit.
    - Stop bit 1: push the byte if the FIFO is not full; otherwise drop it and set overrun. Go to IDLE.
    - Stop bit 0: set framing_error, drop the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents a break condition from being read as repeated frames.
- FIFO push occurs on the STOP sample cycle. The byte is visible in status the following cycle.
- Register map (full 32-bit address match; other addresses are ignored and reads return 0):
  - BASE+0 read, status: bit0 = FIFO not empty, bit1 = overrun, bit2 = framing_error, bits[7:4] = occupancy (saturates at 15), rest 0.
  - BASE+0 write: write-1-to-clear. io_write_data bit1 clears overrun; bit2 clears framing_error.
  - BASE+4 read: returns {24'b0, head byte} and pops the head in the io_read_en cycle. Reading while empty returns 0 and does not pop.
  - BASE+4 write: ignored.
- io_read_data is registered: it is updated on every io_read_en cycle and holds its value otherwise.
- Simultaneous events:
  - Push and pop in the same cycle when full: the pop frees the entry, the push is accepted, occupancy is unchanged, no overrun.
  - Push and pop in the same cycle when empty: the pop sees empty and returns 0; the push lands, so occupancy becomes 1.
  - Overrun/framing set and W1C clear in the same cycle: set wins.
  - Status read in the same cycle as a push: returns the pre-push value.
- Pointers wrap modulo FIFO_DEPTH. The count register distinguishes full from empty.
- Reset mid-frame: the FSM returns to IDLE, the FIFO is flushed, flags are cleared, and the partial byte is discarded.

Test Plan:
- Reset, then read BASE+0 (0x18) -> io_read_data=0 next cycle; read 0x1C -> 0.
- Drive frame 0xA5 at BAUD_DIVIDE=434 -> status reads 0x11 after the stop bit. Read 0x1C -> 0x000000A5, then status reads 0x00.
- Send 9 frames 0x00..0x08 with no reads (FIFO_DEPTH=8) -> status=0x83 and rx_overrun=1. Reads return 0x00..0x07; byte 0x08 is lost. Write 0x2 to 0x18 -> overrun clears.
- Hold stop bit low on frame 0x3C, then hold the line low for 3 bit times -> framing_error=1, FIFO empty, no extra frames. Release high, send 0x55 -> received correctly. Write 0x4 -> status=0x11.
- Low glitch of 100 cycles (< BAUD_DIVIDE/2) on idle line -> FSM returns to IDLE, no byte pushed, status stays 0x00.
- FIFO full; issue data read on the exact cycle a new frame's stop bit is sampled -> pop returns the oldest byte, new byte accepted, occupancy stays 8, overrun=0.
- Assert reset during bit 4 of a frame -> everything returns to reset values; the next complete frame 0x81 is received cleanly.
